// File: rtl/dbg_char_pkg.sv
// Shared definitions for the debug character transmitter.
//   dbg_char_state_t : serializer FSM states
//   EOT_CHAR         : end-of-test character, raises the sticky eot flag
//   max3             : elaboration-time helper used to size the timing counter
package dbg_char_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } dbg_char_state_t;

    localparam logic [7:0] EOT_CHAR = 8'h04;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dbg_char_fifo.sv
// Synchronous byte FIFO with a registered head-of-queue output.
//   clk, rst  : clock, synchronous active-high reset (control state only)
//   push      : write wr_data (ignored when full)
//   pop       : consume head (ignored when head_vld is low)
//   head      : registered head-of-queue byte, meaningful when head_vld
//   head_vld  : head register holds the oldest entry
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   level     : occupancy, 0..DEPTH
module dbg_char_fifo
    import dbg_char_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               head,
    output logic                     head_vld,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & head_vld;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_ptr_nxt = rd_ptr + AW'(pop_ok);
    assign count_nxt  = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
        // The head register reads an entry only after it has landed in
        // memory, so a byte written into an empty FIFO becomes visible one
        // cycle later; that cycle is part of the push-to-char latency.
        head <= mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push_ok);
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            // Valid only if an entry older than this cycle's push remains.
            head_vld <= ((count - (AW+1)'(pop_ok)) != '0);
        end
    end

endmodule

// File: rtl/dbg_char_tx.sv
// Debug character transmitter: buffers bytes and presents each one on
// char_o with a setup / strobe / hold handshake for the printf decoder.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   in_valid/in_ready  : producer handshake, push = in_valid & in_ready
//   in_data            : byte to send
//   char_o             : byte on the pads
//   strobe_o           : rising edge qualifies char_o
//   busy_o             : transfer in progress or bytes queued
//   eot_o              : sticky, set when EOT_CHAR is strobed
//   level_o            : FIFO occupancy
module dbg_char_tx
    import dbg_char_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic [7:0]             char_o,
    output logic                   strobe_o,
    output logic                   busy_o,
    output logic                   eot_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int MAXC  = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAXC) + 1;

    // The counter is loaded with N-1 and the phase ends when it reads zero,
    // so each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

    dbg_char_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_d;
    logic             strobe_d;
    logic             eot_d;
    logic             pop;
    logic             push;
    logic [7:0]       fifo_head;
    logic             fifo_head_vld;
    logic             fifo_full;
    logic             fifo_empty;

    assign in_ready = ~fifo_full & ~wb_rst_i;
    assign push     = in_valid & in_ready;
    assign busy_o   = (state_q != ST_IDLE) | ~fifo_empty;

    dbg_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .push     (push),
        .pop      (pop),
        .wr_data  (in_data),
        .head     (fifo_head),
        .head_vld (fifo_head_vld),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        char_d   = char_o;
        strobe_d = strobe_o;
        eot_d    = eot_o;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_head_vld) begin
                    pop     = 1'b1;
                    char_d  = fifo_head;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = ST_STROBE;
                    strobe_d = 1'b1;
                    cnt_d    = STROBE_LD;
                    if (char_o == EOT_CHAR) begin
                        eot_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d  = ST_HOLD;
                    strobe_d = 1'b0;
                    cnt_d    = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next byte to keep the
                    // back-to-back period at SETUP+STROBE+HOLD.
                    if (fifo_head_vld) begin
                        pop     = 1'b1;
                        char_d  = fifo_head;
                        cnt_d   = SETUP_LD;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            char_o   <= 8'h00;
            strobe_o <= 1'b0;
            eot_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            char_o   <= char_d;
            strobe_o <= strobe_d;
            eot_o    <= eot_d;
        end
    end

endmodule

// File: tb/tb_dbg_char_tx.sv
module tb_dbg_char_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v0 = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic       r0, s0, b0, e0;
    logic [7:0] c0;
    logic [3:0] l0;

    logic       v1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       r1, s1, b1, e1;
    logic [7:0] c1;
    logic [1:0] l1;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         rt0[$];
    int         rt1[$];
    bit         mon_en   = 1'b0;
    logic       exp_eot0 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbg_char_tx u0 (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .in_valid (v0), .in_ready (r0), .in_data (d0),
        .char_o (c0), .strobe_o (s0), .busy_o (b0), .eot_o (e0), .level_o (l0)
    );

    dbg_char_tx #(
        .DEPTH (2), .SETUP_CYCLES (1), .STROBE_CYCLES (1), .HOLD_CYCLES (1)
    ) u1 (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .in_valid (v1), .in_ready (r1), .in_data (d1),
        .char_o (c1), .strobe_o (s1), .busy_o (b1), .eot_o (e1), .level_o (l1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor for the default instance: every strobe rising edge
    // pops one expected byte; char_o stability is checked around the strobe.
    logic       s0_p = 1'b0;
    logic [7:0] c0_h1 = 8'h00, c0_h2 = 8'h00, held0 = 8'h00, ex0;
    int         hl0 = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (s0 && !s0_p) begin
                rt0.push_back(cyc);
                check("queue0_nonempty", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    ex0 = q0.pop_front();
                    check("char0", 32'(c0), 32'(ex0));
                    exp_eot0 = exp_eot0 | (ex0 == 8'h04);
                    check("eot0_at_rise", 32'(e0), 32'(exp_eot0));
                end
                check("setup0_last", 32'(c0_h1), 32'(c0));
                check("setup0_first", 32'(c0_h2), 32'(c0));
                held0 = c0;
            end else if (s0) begin
                check("strobe0_stable", 32'(c0), 32'(held0));
            end else if (s0_p) begin
                check("hold0_first", 32'(c0), 32'(held0));
                hl0 = 1;
            end else if (hl0 > 0) begin
                check("hold0_last", 32'(c0), 32'(held0));
                hl0 = 0;
            end
        end
        s0_p  = s0;
        c0_h2 = c0_h1;
        c0_h1 = c0;
    end

    logic       s1_p = 1'b0;
    logic [7:0] held1 = 8'h00, ex1;
    always @(negedge clk) begin
        if (mon_en) begin
            if (s1 && !s1_p) begin
                rt1.push_back(cyc);
                check("queue1_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    ex1 = q1.pop_front();
                    check("char1", 32'(c1), 32'(ex1));
                end
                held1 = c1;
            end else if (!s1 && s1_p) begin
                check("hold1", 32'(c1), 32'(held1));
            end
        end
        s1_p = s1;
    end

    // Leaves in_valid asserted so consecutive calls form a held burst.
    task automatic push0(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        v0 = 1'b1;
        d0 = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = r0;
            @(posedge clk); #1;
        end
        if (ok) q0.push_back(b);
        else check("push0_timeout", 32'(ok), 32'd1);
    endtask

    task automatic push1(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        v1 = 1'b1;
        d1 = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = r1;
            @(posedge clk); #1;
        end
        if (ok) q1.push_back(b);
        else check("push1_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 1000 && (b0 || q0.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("idle0_busy", 32'(b0), 32'd0);
        check("idle0_queue", 32'(q0.size()), 32'd0);
    endtask

    task automatic wait_idle1();
        for (int i = 0; i < 1000 && (b1 || q1.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("idle1_busy", 32'(b1), 32'd0);
        check("idle1_queue", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t30;
        repeat (3) @(posedge clk);
        #1;
        check("rdy0_in_reset", 32'(r0), 32'd0);
        check("rdy1_in_reset", 32'(r1), 32'd0);
        rst = 1'b0;
        #1;
        check("rdy0_after_reset", 32'(r0), 32'd1);
        check("char0_reset", 32'(c0), 32'd0);
        check("strobe0_reset", 32'(s0), 32'd0);
        check("eot0_reset", 32'(e0), 32'd0);
        check("level0_reset", 32'(l0), 32'd0);
        check("busy0_reset", 32'(b0), 32'd0);
        mon_en = 1'b1;

        // Single byte with exact cycle timing relative to the accepting edge.
        @(posedge clk); #1;
        push0(8'h41);
        v0 = 1'b0;
        check("single_level", 32'(l0), 32'd1);
        check("single_char_n0", 32'(c0), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("single_char_n1", 32'(c0), 32'd0);
            if (k == 2) check("single_char_n2", 32'(c0), 32'h41);
            check($sformatf("single_strobe_n%0d", k), 32'(s0), 32'((k >= 4 && k <= 7) ? 1 : 0));
            if (k == 9)  check("single_busy_hold", 32'(b0), 32'd1);
            if (k == 10) check("single_busy_idle", 32'(b0), 32'd0);
        end

        // Back-to-back burst "Hi!\n".
        rt0.delete();
        push0(8'h48); push0(8'h69); push0(8'h21); push0(8'h0A);
        v0 = 1'b0;
        wait_idle0();
        check("burst_strobes", 32'(rt0.size()), 32'd4);
        for (int i = 1; i < rt0.size(); i++)
            check($sformatf("burst_period%0d", i), 32'(rt0[i] - rt0[i-1]), 32'd8);

        // Fill the FIFO while the first byte is in flight.
        push0(8'h30);
        t30 = cyc;
        for (int i = 0; i < 8; i++) push0(8'h50 + 8'(i));
        check("full_level", 32'(l0), 32'd8);
        check("full_ready", 32'(r0), 32'd0);
        push0(8'h58);
        v0 = 1'b0;
        check("full_ninth_cycle", 32'(cyc - t30), 32'd11);
        check("full_ninth_char", 32'(c0), 32'h50);
        check("full_ninth_level", 32'(l0), 32'd8);
        wait_idle0();

        // End-of-test flag.
        check("eot_before", 32'(e0), 32'd0);
        push0(8'h4F); push0(8'h4B); push0(8'h04); push0(8'h41);
        v0 = 1'b0;
        wait_idle0();
        check("eot_sticky", 32'(e0), 32'd1);

        // Reset in the middle of a strobe with three bytes queued.
        push0(8'h61); push0(8'h62); push0(8'h63); push0(8'h64);
        v0 = 1'b0;
        for (int i = 0; i < 50 && !s0; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_strobe_high", 32'(s0), 32'd1);
        check("rst_mid_level", 32'(l0), 32'd3);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_strobe", 32'(s0), 32'd0);
        check("rst_mid_char", 32'(c0), 32'd0);
        check("rst_mid_level0", 32'(l0), 32'd0);
        check("rst_mid_eot", 32'(e0), 32'd0);
        q0.delete();
        q1.delete();
        exp_eot0 = 1'b0;
        rt0.delete();
        rt1.delete();
        @(negedge clk); #1;
        mon_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_strobes", 32'(rt0.size()), 32'd0);
        check("rst_busy", 32'(b0), 32'd0);

        // Minimal timing with a two-entry FIFO.
        push1(8'hA0);
        push1(8'hA1);
        check("corner_full_level", 32'(l1), 32'd2);
        check("corner_full_ready", 32'(r1), 32'd0);
        for (int i = 2; i < 10; i++) push1(8'hA0 + 8'(i));
        v1 = 1'b0;
        wait_idle1();
        check("corner_strobes", 32'(rt1.size()), 32'd10);
        for (int i = 1; i < rt1.size(); i++)
            check($sformatf("corner_period%0d", i), 32'(rt1[i] - rt1[i-1]), 32'd3);
        check("corner_level_end", 32'(l1), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
